rv_regfile_scb: RTL

RV_REGFILE_SCB -- requirements
Module: rv_regfile_scb

---
 rtl/rv_regfile_scb_pkg.sv | 9 +
 rtl/rv_regfile_scb_regmem_port.sv | 41 ++++
 rtl/rv_regfile_scb.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv_regfile_scb_pkg.sv
// Shared types for the register file with scoreboard: sweep FSM state encodings.
package rv_regfile_scb_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rv_regfile_scb_regmem_port.sv
// One read port's private copy of the register array: 1R1W, registered read,
// held address with stall, write-through on capture and refresh while stalled.
module rv_regmem_port
  import rv_regfile_scb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] haddr_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents come only from writes (the top-level sweep clears it).
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      haddr_o <= '0;
      rdata_o <= '0;
    end else if (!stall_i) begin
      haddr_o <= raddr_i;
      rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
    end else if (we_i && (waddr_i == haddr_o)) begin
      rdata_o <= wdata_i;
    end
  end

endmodule

// File: rtl/rv_regfile_scb.sv
// Multi-port register file with zero-init sweep, pending-write scoreboard,
// optional hardwired zero register and a combinational late bypass.
module rv_regfile_scb
  import rv_regfile_scb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ready_o,
  input  logic                     rd_stall_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        busy_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     byp_en_i,
  input  logic [ADDR_W-1:0]        byp_addr_i,
  input  logic [DATA_W-1:0]        byp_data_i,
  input  logic                     sb_set_i,
  input  logic [ADDR_W-1:0]        sb_set_addr_i
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_e         state_q;
  logic [ADDR_W-1:0] sweep_cnt_q;
  logic [DEPTH-1:0]  busy_q;

  logic              wr_ok, set_ok, byp_ok, in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign in_ready = (state_q == ST_READY);
  assign wr_ok    = wr_en_i  && !((ZERO_REG != 0) && (wr_addr_i == '0));
  assign set_ok   = sb_set_i && !((ZERO_REG != 0) && (sb_set_addr_i == '0));
  assign byp_ok   = byp_en_i && !((ZERO_REG != 0) && (byp_addr_i == '0));

  // The sweep owns the write port until every entry has been cleared.
  assign mem_we    = in_ready ? wr_ok : 1'b1;
  assign mem_waddr = in_ready ? wr_addr_i : sweep_cnt_q;
  assign mem_wdata = in_ready ? wr_data_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
      ready_o     <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_cnt_q <= sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == '1) begin
            state_q <= ST_READY;
            ready_o <= 1'b1;
          end
        end
        default: ready_o <= 1'b1;
      endcase
    end
  end

  // Set is applied after clear so a same-edge set/clear leaves the entry pending.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else if (in_ready) begin
      if (wr_ok)  busy_q[wr_addr_i]     <= 1'b0;
      if (set_ok) busy_q[sb_set_addr_i] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] rdata;
    logic              zero_hit;

    rv_regmem_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .stall_i (rd_stall_i),
      .raddr_i (rd_addr_i[k*ADDR_W +: ADDR_W]),
      .rdata_o (rdata),
      .haddr_o (haddr)
    );

    assign zero_hit = (ZERO_REG != 0) && (haddr == '0);

    assign rd_data_o[k*DATA_W +: DATA_W] =
        (!in_ready || zero_hit)             ? '0         :
        (byp_ok && (byp_addr_i == haddr))   ? byp_data_i : rdata;

    assign busy_o[k] = in_ready && !zero_hit && busy_q[haddr];
  end

endmodule
